// File: rtl/pa_upc_pkg.sv
// Shared definitions for the execute stage: opcodes, the hardwired-zero register
// index and the multiplier FSM state encoding.
package pa_upc_pkg;

    localparam logic [6:0] OP_NOP  = 7'h00;
    localparam logic [6:0] OP_ADD  = 7'h01;
    localparam logic [6:0] OP_SUB  = 7'h02;
    localparam logic [6:0] OP_MUL  = 7'h03;
    localparam logic [6:0] OP_LDB  = 7'h10;
    localparam logic [6:0] OP_LDW  = 7'h11;
    localparam logic [6:0] OP_STB  = 7'h12;
    localparam logic [6:0] OP_STW  = 7'h13;
    localparam logic [6:0] OP_MOV  = 7'h14;
    localparam logic [6:0] OP_BEQ  = 7'h30;
    localparam logic [6:0] OP_JUMP = 7'h31;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/iterative_multiplier.sv
// Shift-and-add multiplier consuming one slice of op_b per cycle; the product is
// presented in DONE, MUL_CYCLES cycles after start is first seen in IDLE.
module iterative_multiplier
    import pa_upc_pkg::*;
#(
    parameter int MUL_CYCLES = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    localparam int STEPS   = MUL_CYCLES - 1;
    localparam int SLICE_W = 32 / STEPS;
    localparam int CNT_W   = $clog2(STEPS + 1);
    localparam logic [31:0] SLICE_W_L  = 32'(SLICE_W);
    localparam logic [31:0] SLICE_MASK = (SLICE_W == 32) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << SLICE_W) - 32'd1);

    function automatic logic [31:0] mul_step(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] shamt);
        return (a * ((b >> shamt) & SLICE_MASK)) << shamt;
    endfunction

    mul_state_e        r_state;
    mul_state_e        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_op_a;
    logic [31:0]       r_op_b;
    logic [31:0]       r_acc;
    logic [31:0]       w_shamt;
    logic [31:0]       w_partial;

    // The IDLE cycle already performs slice 0 from the live operands, so the
    // four steps fit in IDLE + three BUSY cycles and DONE lands on cycle five.
    assign w_shamt   = (r_state == MUL_IDLE) ? 32'd0 : (32'(r_cnt) * SLICE_W_L);
    assign w_partial = (r_state == MUL_IDLE) ? mul_step(op_a, op_b, w_shamt)
                                             : mul_step(r_op_a, r_op_b, w_shamt);

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            MUL_IDLE: begin
                if (start) begin
                    w_next = (STEPS == 1) ? MUL_DONE : MUL_BUSY;
                end else begin
                    w_next = MUL_IDLE;
                end
            end
            MUL_BUSY: begin
                if (r_cnt == CNT_W'(STEPS - 1)) begin
                    w_next = MUL_DONE;
                end else begin
                    w_next = MUL_BUSY;
                end
            end
            MUL_DONE: w_next = MUL_IDLE;
            default:  w_next = MUL_IDLE;
        endcase
    end

    // State register, operand latches, step counter and accumulator.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= MUL_IDLE;
            r_cnt   <= '0;
            r_op_a  <= 32'd0;
            r_op_b  <= 32'd0;
            r_acc   <= 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                MUL_IDLE: begin
                    if (start) begin
                        r_op_a <= op_a;
                        r_op_b <= op_b;
                        r_acc  <= w_partial;
                        r_cnt  <= CNT_W'(1);
                    end
                end
                MUL_BUSY: begin
                    r_acc <= r_acc + w_partial;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign busy    = (r_state == MUL_BUSY);
    assign done    = (r_state == MUL_DONE);
    assign product = r_acc;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, address generation, branch resolution,
// and stall generation around the iterative multiplier.
module execute_stage
    import pa_upc_pkg::*;
#(
    parameter int MUL_CYCLES = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] x_pc,
    input  logic [6:0]  x_opcode,
    input  logic [4:0]  x_src_reg_1,
    input  logic [4:0]  x_src_reg_2,
    input  logic [31:0] x_read_data_1,
    input  logic [31:0] x_read_data_2,
    input  logic [31:0] x_mem_offset,
    input  logic [31:0] x_brn_offset,
    input  logic [19:0] x_jmp_offset,
    input  logic        x_alu_imm_src,
    input  logic        m_reg_write,
    input  logic [4:0]  m_dst_reg,
    input  logic [31:0] m_alu_result,
    input  logic        w_reg_write,
    input  logic [4:0]  w_dst_reg,
    input  logic [31:0] w_write_data,
    output logic        x_stall,
    output logic [31:0] x_alu_result,
    output logic [31:0] x_store_data,
    output logic        x_branch_taken,
    output logic [31:0] x_branch_target
);

    // Memory stage has priority: it holds the younger write to the register.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf_data);
        if ((src != REG_ZERO) && m_reg_write && (m_dst_reg == src)) begin
            return m_alu_result;
        end else if ((src != REG_ZERO) && w_reg_write && (w_dst_reg == src)) begin
            return w_write_data;
        end else begin
            return rf_data;
        end
    endfunction

    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic [31:0] w_op_b;
    logic [31:0] w_jmp_ext;
    logic        w_is_mul;
    logic        w_mul_busy;
    logic        w_mul_done;
    logic [31:0] w_product;
    logic [31:0] w_result;
    logic        w_taken;
    logic [31:0] w_target;

    assign w_op1     = fwd(x_src_reg_1, x_read_data_1);
    assign w_op2     = fwd(x_src_reg_2, x_read_data_2);
    assign w_op_b    = x_alu_imm_src ? x_mem_offset : w_op2;
    assign w_jmp_ext = {{12{x_jmp_offset[19]}}, x_jmp_offset};
    assign w_is_mul  = (x_opcode == OP_MUL);

    iterative_multiplier #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (w_is_mul),
        .op_a    (w_op1),
        .op_b    (w_op2),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_product)
    );

    // ALU, address and branch resolution, all combinational.
    always_comb begin
        w_result = 32'd0;
        w_taken  = 1'b0;
        w_target = 32'd0;
        case (x_opcode)
            OP_ADD: w_result = w_op1 + w_op_b;
            OP_SUB: w_result = w_op1 - w_op_b;
            OP_MUL: begin
                if (w_mul_done) begin
                    w_result = w_product;
                end else begin
                    w_result = 32'd0;
                end
            end
            OP_LDB, OP_LDW, OP_STB, OP_STW: w_result = w_op1 + x_mem_offset;
            OP_MOV: w_result = w_op2;
            OP_BEQ: begin
                w_taken  = (w_op1 == w_op2);
                w_target = x_pc + x_brn_offset;
            end
            OP_JUMP: begin
                w_taken  = 1'b1;
                w_target = x_pc + w_jmp_ext;
            end
            default: w_result = 32'd0;
        endcase
    end

    // A MUL seen in IDLE stalls immediately; DONE releases the pipeline.
    assign x_stall         = ~reset & (w_mul_busy | (w_is_mul & ~w_mul_done));
    assign x_alu_result    = reset ? 32'd0 : w_result;
    assign x_store_data    = reset ? 32'd0 : w_op2;
    assign x_branch_taken  = ~reset & w_taken;
    assign x_branch_target = reset ? 32'd0 : w_target;

endmodule
